sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Parametrised synchronous FIFO and successor to the 8-bit, 4-deep UART-side FIFO.
- Generalised data width and depth. Adds an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags.
- Sits between APB peripheral register blocks and their serial engines (UART TX/RX, SPI), where firmware polls level and error status.

Parameters:
- DATA_WIDTH, 8: data word width in bits, ≥1.
- DEPTH, 4: number of entries; power of two, ≥2.
- AFULL_THRESH, DEPTH-1: almost_full asserts when count ≥ this value; legal range 1..DEPTH.
- AEMPTY_THRESH, 1: almost_empty asserts when count ≤ this value; legal range 0..DEPTH-1.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- wr, input, 1: write request.
- rd, input, 1: read request; pops the current head.
- flush, input, 1: synchronous clear of contents.
- clr_err, input, 1: synchronous clear of the error flags.
- wdata, input, DATA_WIDTH: write data.
- rdata, output, DATA_WIDTH: head-of-queue data (show-ahead).
- full, output, 1: count == DEPTH.
- empty, output, 1: count == 0.
- almost_full, output, 1: count ≥ AFULL_THRESH.
- almost_empty, output, 1: count ≤ AEMPTY_THRESH.
- count, output, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- overflow, output, 1: sticky; a write was dropped.
- underflow, output, 1: sticky; a read was dropped.

Behaviour:
- Reset (rst_n low, asynchronous): pointers = 0; count = 0; empty = 1; full = 0; almost_full = 0; almost_empty = 1; overflow = 0; underflow = 0. Storage array is not reset.
- Pointers are $clog2(DEPTH)+1 bits wide. The MSB disambiguates full from empty, and pointers wrap naturally at 2·DEPTH.
- Accepted write: wa = wr & ~full. Accepted read: ra = rd & ~empty. Both are evaluated on the registered flags of the current cycle.
- On wa: mem[wptr] <= wdata, wptr += 1.
- On ra: rptr += 1.
- Count update: +1 on wa only, -1 on ra only, unchanged on both or neither.
- Simultaneous wr & rd:
  - Not empty and not full: both accepted, count unchanged.
  - Empty: write only.
  - Full: read only; the write is dropped.
- rdata = mem[rptr[$clog2(DEPTH)-1:0]], combinational from the registered pointer. Zero read latency: the head is valid whenever empty = 0. rdata is unspecified when empty = 1.
- A word written at edge N appears on rdata after edge N when the FIFO was empty.
- All status outputs decode from registered count/pointers, so they update the cycle after the causing edge. No combinational path from wr/rd to flags.
- Flush: has priority over wr/rd in the same cycle. Pointers and count go to 0, empty = 1. Error flags are NOT cleared by flush.
- overflow: set on the edge where wr & full & ~flush.
- underflow: set on the edge where rd & empty & ~flush. This includes the wr & rd-while-empty case, where the write is still accepted.
- clr_err clears both error flags. If a set condition coincides with clr_err, set wins.
- count never exceeds DEPTH or goes below 0 under any input sequence.
- Reset asserted mid-operation: all state returns to reset values immediately. In-flight requests are discarded.

Optional Feature:
- Macro: SYNC_FIFO_ERR_FLAGS_EN.
- Defined: overflow/underflow logic and clr_err behave as above.
- Undefined: overflow and underflow are tied to 0, clr_err is ignored, and no error flag registers are generated. All other behaviour is identical and ports remain present.

Test Plan (DATA_WIDTH=8, DEPTH=4, AFULL_THRESH=3, AEMPTY_THRESH=1, macro defined):
1. Release reset, write 0xA1, 0xB2, 0xC3, 0xD4 on 4 consecutive cycles.
   - Required: count steps 1, 2, 3, 4.
   - almost_empty drops when count = 2; almost_full rises at count = 3; full rises at count = 4.
   - rdata = 0xA1 from the cycle after the first write.
2. From full, assert wr with 0xEE for one cycle.
   - Required: overflow = 1, count stays 4, contents unchanged.
   - Then read 4 times: rdata sequence 0xA1, 0xB2, 0xC3, 0xD4; empty = 1 after the fourth read.
3. Write/read wrap-around: 10 pushes of 0x00..0x09, each popped 2 cycles later.
   - Required: data returns in order, count never exceeds 2, pointers wrap past 2·DEPTH.
4. Simultaneous wr & rd:
   - With count = 2: count stays 2, order preserved.
   - With empty: write accepted, count = 1, underflow = 1.
   - With full: count = 3, overflow = 1.
5. Fill to 3, then assert flush together with wr = 1 (0x55).
   - Required: count = 0, empty = 1, 0x55 not stored, error flags unchanged.
   - clr_err then clears overflow and underflow to 0.
6. Drive rst_n low mid-burst at count = 2, asynchronously between edges.
   - Required: count = 0, empty = 1, flags at reset values immediately, before the next clk edge.

Source files
------------

// File: rtl/sync_fifo_param_if.sv
// Handshake/status bundle between a register block and sync_fifo_param.
// master drives requests and write data; slave (the FIFO) returns head data and status.
interface sync_fifo_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  wr;
  logic                  rd;
  logic                  flush;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr, rd, flush, clr_err, wdata,
    input  rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr, rd, flush, clr_err, wdata,
    output rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised show-ahead synchronous FIFO with level flags, flush and sticky errors.
// Define SYNC_FIFO_ERR_FLAGS_EN to build the overflow/underflow registers and clr_err.
module sync_fifo_param #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 4,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input logic              clk,
  input logic              rst_n,
  sync_fifo_param_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]         wptr, rptr, cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  full, empty, wa, ra;

  // Flags come from registered count only, so wr/rd never reach them combinationally.
  assign full  = (cnt == PW'(DEPTH));
  assign empty = (cnt == '0);
  assign wa    = bus.wr & ~full  & ~bus.flush;
  assign ra    = bus.rd & ~empty & ~bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (bus.flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wa) wptr <= wptr + PW'(1);
      if (ra) rptr <= rptr + PW'(1);
      case ({wa, ra})
        2'b10:   cnt <= cnt + PW'(1);
        2'b01:   cnt <= cnt - PW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wa) mem[wptr[AW-1:0]] <= bus.wdata;
  end

  assign bus.rdata        = mem[rptr[AW-1:0]];
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (cnt >= PW'(AFULL_THRESH));
  assign bus.almost_empty = (cnt <= PW'(AEMPTY_THRESH));
  assign bus.count        = cnt;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic ovf, udf, ovf_set, udf_set;

  // Underflow still flags a wr&rd on empty even though the write lands.
  assign ovf_set = bus.wr & full  & ~bus.flush;
  assign udf_set = bus.rd & empty & ~bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (ovf_set)          ovf <= 1'b1;
      else if (bus.clr_err) ovf <= 1'b0;
      if (udf_set)          udf <= 1'b1;
      else if (bus.clr_err) udf <= 1'b0;
    end
  end

  assign bus.overflow  = ovf;
  assign bus.underflow = udf;
`else
  logic unused_clr_err;
  assign unused_clr_err = bus.clr_err;
  assign bus.overflow   = 1'b0;
  assign bus.underflow  = 1'b0;
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: queue-based reference model, decoupled monitor.
module tb_sync_fifo_param;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int AFT = 3;
  localparam int AET = 1;
  localparam int CW = $clog2(DEPTH) + 1;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic          full, empty, af, ae, ovf, udf;
    logic [DW-1:0] head;
  } st_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bif ();

  sync_fifo_param #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AFT), .AEMPTY_THRESH(AET)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mq [$];   // reference contents
  logic [DW-1:0] xq [$];   // expected pop data
  st_t           sq [$];   // expected status after each edge
  logic          m_ovf = 1'b0, m_udf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_status();
    st_t s;
    int  n;
    n       = mq.size();
    s.cnt   = CW'(n);
    s.full  = (n == DEPTH);
    s.empty = (n == 0);
    s.af    = (n >= AFT);
    s.ae    = (n <= AET);
    s.ovf   = m_ovf;
    s.udf   = m_udf;
    s.head  = (n > 0) ? mq[0] : '0;
    sq.push_back(s);
  endtask

  // Drive one cycle of requests, advance the model across the edge, queue expectations.
  task automatic step(input logic w, input logic r, input logic f, input logic c,
                      input logic [DW-1:0] d);
    int   n;
    logic so, su;
    bif.wr = w; bif.rd = r; bif.flush = f; bif.clr_err = c; bif.wdata = d;
    n = mq.size();
    if (r && n > 0 && !f) xq.push_back(mq[0]);
    @(posedge clk);
    so = w && (n == DEPTH) && !f;
    su = r && (n == 0) && !f;
    if (f) mq.delete();
    else begin
      if (r && n > 0) void'(mq.pop_front());
      if (w && (mq.size() < DEPTH) && !(n == DEPTH)) mq.push_back(d);
    end
    if (ERR_EN) begin
      m_ovf = so ? 1'b1 : (c ? 1'b0 : m_ovf);
      m_udf = su ? 1'b1 : (c ? 1'b0 : m_udf);
    end
    #1;
    push_status();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Monitor: compare status every cycle and pop data whenever the DUT is about to pop.
  always @(negedge clk) begin
    st_t s;
    if (sq.size() > 0) begin
      s = sq.pop_front();
      chk("count", 32'(bif.count), 32'(s.cnt));
      chk("flags{full,empty,af,ae}",
          32'({bif.full, bif.empty, bif.almost_full, bif.almost_empty}),
          32'({s.full, s.empty, s.af, s.ae}));
      chk("err{ovf,udf}", 32'({bif.overflow, bif.underflow}), 32'({s.ovf, s.udf}));
      if (!s.empty) chk("rdata_head", 32'(bif.rdata), 32'(s.head));
    end
    if (rst_n && bif.rd && !bif.empty && !bif.flush) begin
      if (xq.size() == 0) chk("pop_unexpected", 32'(1), 32'(0));
      else chk("pop_data", 32'(bif.rdata), 32'(xq.pop_front()));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] init_data [4];
    rst_n = 1'b0;
    bif.wr = 1'b0; bif.rd = 1'b0; bif.flush = 1'b0; bif.clr_err = 1'b0; bif.wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    push_status();

    // Fill with four words, then attempt an overflow write.
    init_data[0] = 8'hA1; init_data[1] = 8'hB2; init_data[2] = 8'hC3; init_data[3] = 8'hD4;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, init_data[i]);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'hEE);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0);

    // Wrap-around: each push popped two cycles later.
    for (int i = 0; i < 12; i++)
      step(i < 10, i >= 2, 1'b0, 1'b0, DW'(i));

    // Simultaneous wr&rd at count 2, at empty, and at full.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h22);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h33);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h44);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, DW'(8'h60 + i));
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h77);

    // Flush beats a coincident write; errors survive flush, then clr_err.
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h55);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    idle();

    // Randomised traffic, write-heavy then read-heavy.
    for (int i = 0; i < 400; i++) begin
      int wp, rp;
      wp = (i < 200) ? 70 : 35;
      rp = (i < 200) ? 35 : 70;
      step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 8, DW'($urandom));
    end

    // Asynchronous reset between edges with count at 2 and a write in flight.
    step(1'b1, 1'b0, 1'b1, 1'b1, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h9A);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h9B);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h9C);
    bif.wr = 1'b1; bif.rd = 1'b1; bif.wdata = 8'h9D;
    #2 rst_n = 1'b0;
    #1;
    sq.delete();
    xq.delete();
    mq.delete();
    m_ovf = 1'b0; m_udf = 1'b0;
    chk("rst_count", 32'(bif.count), 32'(0));
    chk("rst_flags{full,empty,af,ae}",
        32'({bif.full, bif.empty, bif.almost_full, bif.almost_empty}), 32'(4'b0101));
    chk("rst_err{ovf,udf}", 32'({bif.overflow, bif.underflow}), 32'(0));
    @(posedge clk);
    #1;
    bif.wr = 1'b0; bif.rd = 1'b0;
    rst_n = 1'b1;
    push_status();

    for (int i = 0; i < 100; i++)
      step($urandom_range(0, 1), $urandom_range(0, 1), 1'b0,
           $urandom_range(0, 99) < 5, DW'($urandom));

    for (int i = 0; i < 3; i++) idle();
    @(negedge clk);
    #1;
    chk("status_queue_drained", 32'(sq.size()), 32'(0));
    chk("pop_queue_drained", 32'(xq.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
